// File: rtl/tetris_pkg.sv
// Shared board geometry, pixel/coordinate types and painter state encoding.
package tetris_pkg;

  localparam int TILE_PX    = 16;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;
  localparam int SCREEN_W   = 640;
  localparam int BOARD_X0   = 240;
  localparam int BOARD_Y0   = 0;

  typedef logic [15:0] color_t;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
  } tile_coord_t;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} painter_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [3:0] first_set(input logic [15:0] m);
    first_set = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (m[i-1]) first_set = 4'(i - 1);
    end
  endfunction

endpackage

// File: rtl/tile_scan.sv
// Walks the pixels of one tile row-major and presents the frame-buffer address.
module tile_scan import tetris_pkg::*; #(
  parameter int TILE_PX  = tetris_pkg::TILE_PX,
  parameter int BOARD_X0 = tetris_pkg::BOARD_X0,
  parameter int BOARD_Y0 = tetris_pkg::BOARD_Y0,
  parameter int SCREEN_W = tetris_pkg::SCREEN_W,
  parameter int ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              advance,
  input  tile_coord_t       tile,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  localparam int PW = $clog2(TILE_PX);

  tile_coord_t   tile_q;
  logic [PW-1:0] px_q, py_q;
  logic [ADDR_W-1:0] row, col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tile_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else if (start) begin
      tile_q <= tile;
      px_q   <= '0;
      py_q   <= '0;
    end else if (advance) begin
      px_q <= px_q + 1'b1;
      if (px_q == '1) py_q <= py_q + 1'b1;
    end
  end

  always_comb begin
    row  = ADDR_W'(BOARD_Y0) + (ADDR_W'(tile_q.y) << PW) + ADDR_W'(py_q);
    col  = ADDR_W'(BOARD_X0) + (ADDR_W'(tile_q.x) << PW) + ADDR_W'(px_q);
    addr = row * ADDR_W'(SCREEN_W) + col;
  end

  assign last_pixel = (px_q == '1) && (py_q == '1);

endmodule

// File: rtl/block_painter.sv
// Per frame tick: snapshot the piece, erase vacated tiles, then paint occupied tiles.
module block_painter import tetris_pkg::*; #(
  parameter int          NUM_BLOCKS = 4,
  parameter int          TILE_PX    = tetris_pkg::TILE_PX,
  parameter int          BOARD_COLS = tetris_pkg::BOARD_COLS,
  parameter int          BOARD_ROWS = tetris_pkg::BOARD_ROWS,
  parameter int          BOARD_X0   = tetris_pkg::BOARD_X0,
  parameter int          BOARD_Y0   = tetris_pkg::BOARD_Y0,
  parameter int          SCREEN_W   = tetris_pkg::SCREEN_W,
  parameter int          ADDR_W     = 19,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [6:0]        blockXPos  [16],
  input  logic [6:0]        blockYPos  [16],
  input  logic [6:0]        blockXPrev [16],
  input  logic [6:0]        blockYPrev [16],
  input  logic [15:0]       blockColor,
  input  logic              fb_ready,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              busy,
  output logic              done,
  output logic              frame_dropped
);

  painter_state_t state_q, nxt_state;
  logic [1:0]  sync_q;
  logic        tick_q, start;
  tile_coord_t cur_q [16];
  tile_coord_t prv_q [16];
  color_t      color_q, nxt_color;
  logic [15:0] er_q, dr_q, em_in, dm_in, er_rem, dr_rem;
  logic [3:0]  blk_q, nxt_blk;
  logic        fb_we_q, busy_q, done_q, drop_q;
  color_t      fb_data_q;
  tile_coord_t nxt_tile;
  logic        accept, tile_end, go, last_pixel;
  logic [ADDR_W-1:0] scan_addr;

  function automatic logic in_board(input logic [6:0] x, input logic [6:0] y);
    return (x < 7'(BOARD_COLS)) && (y < 7'(BOARD_ROWS));
  endfunction

  assign start    = sync_q[1] & ~tick_q;
  assign accept   = fb_we_q & fb_ready;
  assign tile_end = accept & last_pixel;

  // Erase skips tiles still covered by the piece and repeated prev tiles,
  // so each vacated tile is cleared exactly once and nothing flickers.
  always_comb begin
    em_in = '0;
    dm_in = '0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      dm_in[b] = in_board(blockXPos[b], blockYPos[b]);
      em_in[b] = in_board(blockXPrev[b], blockYPrev[b]);
      for (int unsigned c = 0; c < NUM_BLOCKS; c++) begin
        if (blockXPrev[b] == blockXPos[c] && blockYPrev[b] == blockYPos[c]) em_in[b] = 1'b0;
        if (c < b && blockXPrev[b] == blockXPrev[c] && blockYPrev[b] == blockYPrev[c])
          em_in[b] = 1'b0;
      end
    end
  end

  // Next tile is picked in the same cycle the previous one completes,
  // so skipped tiles cost no cycles and writes stay back-to-back.
  always_comb begin
    er_rem = '0;
    dr_rem = '0;
    go     = 1'b0;
    case (state_q)
      IDLE:  begin er_rem = em_in; dr_rem = dm_in; go = start; end
      ERASE: begin er_rem = er_q & ~(16'h0001 << blk_q); dr_rem = dr_q; go = tile_end; end
      DRAW:  begin dr_rem = dr_q & ~(16'h0001 << blk_q); go = tile_end; end
      default: ;
    endcase
    nxt_blk = (er_rem != '0) ? first_set(er_rem) : first_set(dr_rem);
    if (er_rem != '0)      nxt_state = ERASE;
    else if (dr_rem != '0) nxt_state = DRAW;
    else                   nxt_state = DONE;
    if (state_q == IDLE) begin
      nxt_tile.x = (nxt_state == ERASE) ? blockXPrev[nxt_blk] : blockXPos[nxt_blk];
      nxt_tile.y = (nxt_state == ERASE) ? blockYPrev[nxt_blk] : blockYPos[nxt_blk];
      nxt_color  = blockColor;
    end else begin
      nxt_tile  = (nxt_state == ERASE) ? prv_q[nxt_blk] : cur_q[nxt_blk];
      nxt_color = color_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      tick_q    <= 1'b0;
      color_q   <= '0;
      er_q      <= '0;
      dr_q      <= '0;
      blk_q     <= '0;
      fb_we_q   <= 1'b0;
      fb_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      for (int unsigned b = 0; b < 16; b++) begin
        cur_q[b] <= '0;
        prv_q[b] <= '0;
      end
    end else begin
      sync_q <= {sync_q[0], frame_clk};
      tick_q <= sync_q[1];
      done_q <= 1'b0;
      drop_q <= start && (state_q != IDLE);
      if (state_q == IDLE && start) begin
        busy_q  <= 1'b1;
        color_q <= blockColor;
        for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
          cur_q[b] <= '{x: blockXPos[b],  y: blockYPos[b]};
          prv_q[b] <= '{x: blockXPrev[b], y: blockYPrev[b]};
        end
      end
      if (state_q == DONE) begin
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end
      if (go) begin
        state_q   <= nxt_state;
        blk_q     <= nxt_blk;
        er_q      <= er_rem;
        dr_q      <= dr_rem;
        fb_we_q   <= (nxt_state != DONE);
        fb_data_q <= (nxt_state == ERASE) ? BG_COLOR : nxt_color;
        done_q    <= (nxt_state == DONE);
      end
    end
  end

  tile_scan #(
    .TILE_PX (TILE_PX),
    .BOARD_X0(BOARD_X0),
    .BOARD_Y0(BOARD_Y0),
    .SCREEN_W(SCREEN_W),
    .ADDR_W  (ADDR_W)
  ) u_scan (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (go && (nxt_state != DONE)),
    .advance   (accept),
    .tile      (nxt_tile),
    .addr      (scan_addr),
    .last_pixel(last_pixel)
  );

  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_we_q ? scan_addr : '0;
  assign fb_data       = fb_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_dropped = drop_q;

endmodule
